// File: rtl/calc_pkg.sv
// Shared types and frame constants for the calculator result transmitter.
// Holds the transmit FSM state enum and the line levels used in each frame.
package calc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START_BIT,
    DATA_BITS,
    STOP_BIT,
    NEXT_WORD
  } tx_state_e;

  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL = 1'b1;
  localparam int FRAMES_PER_XFER = 2;

endpackage

// File: rtl/baud_tick_gen.sv
// Bit-period counter: bit_tick pulses on the last enabled cycle of a bit.
// Ports: clk, reset (sync, active-low), enable, clear -> bit_tick.
module baud_tick_gen #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic bit_tick
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign bit_tick = enable && !clear && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear || bit_tick) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!reset) cnt_q <= '0;
    else if (enable) cnt_q <= cnt_d;
  end

endmodule

// File: rtl/calc_result_tx.sv
// Serialises a result word then a carry word as two UART-style frames.
// Ports: clk, reset, enable, start, dataC, carry -> tx, busy, done.
module calc_result_tx
  import calc_pkg::*;
#(
  parameter int WORD_LENGTH  = 6,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   start,
  input  logic [WORD_LENGTH-1:0] dataC,
  input  logic [WORD_LENGTH-1:0] carry,
  output logic                   tx,
  output logic                   busy,
  output logic                   done
);

  localparam int BCW = (WORD_LENGTH > 1) ? $clog2(WORD_LENGTH) : 1;
  localparam int FCW = (FRAMES_PER_XFER > 1) ? $clog2(FRAMES_PER_XFER) : 1;

  tx_state_e              state_q, state_d;
  logic [WORD_LENGTH-1:0] res_q, car_q;
  logic [BCW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [FCW-1:0]         frame_q, frame_d;
  logic                   done_q, done_d;
  logic                   bit_tick, baud_clr;
  logic                   accept, last_bit, last_frame;
  logic [WORD_LENGTH-1:0] cur_word;

  assign accept     = enable && start && (state_q == IDLE);
  assign last_bit   = bit_cnt_q == BCW'(WORD_LENGTH - 1);
  assign last_frame = frame_q == FCW'(FRAMES_PER_XFER - 1);
  assign cur_word   = (frame_q == '0) ? res_q : car_q;

  // Hold the baud counter at zero whenever no bit is on the line.
  assign baud_clr = (state_q == IDLE) || (state_q == NEXT_WORD);

  baud_tick_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .reset   (reset),
    .enable  (enable),
    .clear   (baud_clr),
    .bit_tick(bit_tick)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      frame_q   <= '0;
      done_q    <= 1'b0;
    end else begin
      // done_d already implies enable, so the pulse stays one cycle wide.
      done_q <= done_d;
      if (enable) begin
        state_q   <= state_d;
        bit_cnt_q <= bit_cnt_d;
        frame_q   <= frame_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      res_q <= '0;
      car_q <= '0;
    end else if (accept) begin
      res_q <= dataC;
      car_q <= carry;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    frame_d   = frame_q;
    done_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = START_BIT;
          frame_d = '0;
        end
      end
      START_BIT: begin
        if (bit_tick) state_d = DATA_BITS;
      end
      DATA_BITS: begin
        if (bit_tick) begin
          if (last_bit) begin
            state_d   = STOP_BIT;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      STOP_BIT: begin
        if (bit_tick) begin
          if (last_frame) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = NEXT_WORD;
            frame_d = frame_q + 1'b1;
          end
        end
      end
      NEXT_WORD: state_d = START_BIT;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    tx   = STOP_LEVEL;
    busy = state_q != IDLE;
    done = done_q;
    unique case (state_q)
      START_BIT: tx = START_LEVEL;
      DATA_BITS: tx = cur_word[bit_cnt_q];
      default:   tx = STOP_LEVEL;
    endcase
  end

endmodule

// File: tb/tb_calc_result_tx.sv
// Directed bench for calc_result_tx (WORD_LENGTH=6, CLKS_PER_BIT=4).
// Drives and samples on the falling edge; expected waves are hand-built.
module tb_calc_result_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       start;
  logic [5:0] dataC;
  logic [5:0] carry;
  logic       tx;
  logic       busy;
  logic       done;

  int checks = 0;
  int fails  = 0;

  // Slot levels for 2D then 01: start, 6 data LSB first, stop.
  logic [0:15] slots = 16'b01011011_01000001;

  always #5 clk = ~clk;

  calc_result_tx #(
    .WORD_LENGTH (6),
    .CLKS_PER_BIT(4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .enable(enable),
    .start (start),
    .dataC (dataC),
    .carry (carry),
    .tx    (tx),
    .busy  (busy),
    .done  (done)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0d exp=%0d", tag, $signed(got), $signed(exp));
    end
  endtask

  function automatic logic exp_tx(input int e);
    if (e < 32) return slots[e/4];
    if (e == 32) return 1'b1;
    if (e < 65) return slots[8 + (e - 33) / 4];
    return 1'b1;
  endfunction

  // One transfer of 2D/01 with optional stall, input change,
  // duplicate start or reset at given cycles (-1 = unused).
  task automatic xfer(input string nm, input int stall_at,
                      input int stall_len, input int chg_at,
                      input int dup_at, input int rst_at,
                      input int exp_lat);
    int ec, lat, dcnt, berr, werr;
    ec = 0; lat = -1; dcnt = 0; berr = 0; werr = 0;
    @(negedge clk);
    dataC = 6'h2D; carry = 6'h01;
    start = 1'b1; enable = 1'b1; reset = 1'b1;
    for (int k = 0; k < 240; k++) begin
      @(negedge clk);
      if (rst_at >= 0 && k == rst_at + 1) begin
        chk({nm, "_rst_tx"}, tx, 1);
        chk({nm, "_rst_busy"}, busy, 0);
        chk({nm, "_rst_done"}, done, 0);
        reset = 1'b1;
      end
      if (done) begin
        dcnt++;
        if (lat < 0) lat = k;
      end
      if (rst_at < 0 || k <= rst_at) begin
        if (tx !== exp_tx(ec)) werr++;
        if (lat < 0 && busy !== 1'b1) berr++;
      end
      if (lat >= 0 && k > lat && busy !== 1'b0) berr++;
      if (rst_at >= 0 && k > rst_at && busy !== 1'b0) berr++;
      start = (k == dup_at);
      if (chg_at >= 0 && k >= chg_at) dataC = 6'h3F;
      enable = !(stall_at >= 0 && k >= stall_at && k < stall_at + stall_len);
      if (k == rst_at) reset = 1'b0;
      if (enable) ec++;
      if (lat >= 0 && k >= lat + 4) break;
    end
    start = 1'b0; enable = 1'b1; reset = 1'b1;
    if (rst_at < 0) begin
      chk({nm, "_latency"}, lat, exp_lat);
      chk({nm, "_done_cnt"}, dcnt, 1);
    end else begin
      chk({nm, "_done_cnt"}, dcnt, 0);
    end
    chk({nm, "_wave_err"}, werr, 0);
    chk({nm, "_busy_err"}, berr, 0);
  endtask

  initial begin
    int dcnt, idle, ierr, d1, d2;
    reset = 1'b0; enable = 1'b0; start = 1'b1;
    dataC = 6'h15; carry = 6'h2A;
    repeat (3) @(negedge clk);
    chk("reset_tx", tx, 1);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);

    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("start_while_disabled", busy, 0);
    start = 1'b0; enable = 1'b1;
    @(negedge clk);

    xfer("basic",  -1, 0, -1, -1, -1, 65);
    xfer("chg",    -1, 0,  0, -1, -1, 65);
    xfer("dup",    -1, 0, -1, 10, -1, 65);
    xfer("stall",  10, 7, -1, -1, -1, 72);
    xfer("rst",    -1, 0, -1, -1, 20, 0);
    xfer("after",  -1, 0, -1, -1, -1, 65);

    dcnt = 0; idle = 0; ierr = 0; d1 = -1; d2 = -1;
    @(negedge clk);
    start = 1'b1;
    for (int k = 0; k < 140; k++) begin
      @(negedge clk);
      if (done) begin
        dcnt++;
        if (d1 < 0) d1 = k;
        else if (d2 < 0) d2 = k;
      end
      if (!busy) begin
        idle++;
        if (tx !== 1'b1) ierr++;
      end
    end
    start = 1'b0;
    chk("b2b_done_cnt", dcnt, 2);
    chk("b2b_first_done", d1, 65);
    chk("b2b_gap", d2 - d1, 66);
    chk("b2b_idle_cycles", idle, 2);
    chk("b2b_idle_tx", ierr, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
